drp_scan_ctrl: RTL and testbench

DRP_SCAN_CTRL -- requirements
Module: drp_scan_ctrl

---
 rtl/drp_pkg.sv | 24 ++
 rtl/drp_scan_table.sv | 57 +++++
 rtl/drp_scan_ctrl.sv | 119 +++++++++++
 tb/tb_drp_scan_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drp_pkg.sv
// Shared types and constants for the DRP scan controller and its result table.
package drp_pkg;

  localparam int N_ENTRIES   = 16;
  localparam int TIMEOUT_CYC = 1000;
  localparam int DRP_ADDR_W  = 8;
  localparam int IDX_W       = 4;
  localparam int WDOG_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SCAN,
    ST_ERR
  } scan_state_t;

  // Last table index of the window: length 0 behaves as 1, lengths above 16 as 16.
  function automatic logic [IDX_W-1:0] last_idx(input logic [4:0] num);
    if (num == 5'd0)       return '0;
    else if (num >= 5'd16) return {IDX_W{1'b1}};
    else                   return IDX_W'(num - 5'd1);
  endfunction

endpackage

// File: rtl/drp_scan_table.sv
// 16x16 capture table with valid bits, sticky change flags and a registered host read port.
module drp_scan_table
  import drp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  logic [15:0]          i_wr_data,
  input  logic                 i_host_rd,
  input  logic [IDX_W-1:0]     i_host_idx,
  input  logic                 i_change_clr,
  output logic [15:0]          o_host_data,
  output logic                 o_host_data_vld,
  output logic [N_ENTRIES-1:0] o_change_flag
);

  logic [15:0]          r_mem [N_ENTRIES];
  logic [N_ENTRIES-1:0] r_valid;
  logic [N_ENTRIES-1:0] r_change_flag;
  logic [15:0]          r_host_data;
  logic                 r_host_vld;
  logic [N_ENTRIES-1:0] w_set_mask;

  // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
  always_comb begin
    w_set_mask = '0;
    if (i_wr_en && r_valid[i_wr_idx] && (r_mem[i_wr_idx] != i_wr_data))
      w_set_mask[i_wr_idx] = 1'b1;
  end

  // NOTE: the data array has no reset; the valid bits gate every observable use of it.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
  end

  // NOTE: non-blocking assignments make the host read see the pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= '0;
      r_change_flag <= '0;
      r_host_data   <= '0;
      r_host_vld    <= 1'b0;
    end else begin
      if (i_wr_en) r_valid[i_wr_idx] <= 1'b1;
      r_change_flag <= (i_change_clr ? '0 : r_change_flag) | w_set_mask;
      r_host_vld    <= i_host_rd;
      if (i_host_rd)
        r_host_data <= r_valid[i_host_idx] ? r_mem[i_host_idx] : 16'h0000;
    end
  end

  assign o_host_data     = r_host_data;
  assign o_host_data_vld = r_host_vld;
  assign o_change_flag   = r_change_flag;

endmodule

// File: rtl/drp_scan_ctrl.sv
// Sweeps a window of DRP addresses, capturing each returned word into a table,
// with change tracking, sweep statistics and a watchdog on the read engine.
module drp_scan_ctrl
  import drp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_en,
  input  logic [DRP_ADDR_W-1:0] base_addr,
  input  logic [4:0]            num_entries,
  input  logic                  rd_valid,
  input  logic [15:0]           rd_data,
  output logic [DRP_ADDR_W-1:0] req_addr,
  input  logic                  host_rd,
  input  logic [IDX_W-1:0]      host_idx,
  output logic [15:0]           host_data,
  output logic                  host_data_vld,
  input  logic                  change_clr,
  output logic [N_ENTRIES-1:0]  change_flag,
  output logic                  sweep_done,
  output logic [15:0]           sweep_count,
  output logic                  timeout_err
);

  scan_state_t           r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_last_idx;
  logic [DRP_ADDR_W-1:0] r_base;
  logic [DRP_ADDR_W-1:0] r_req_addr;
  logic [WDOG_W-1:0]     r_wdog;
  logic                  r_sweep_done;
  logic [15:0]           r_sweep_count;
  logic                  r_timeout_err;
  logic                  w_capture;
  logic                  w_wrap;
  logic [IDX_W-1:0]      w_next_idx;

  assign w_capture  = (r_state == ST_SCAN) && scan_en && rd_valid;
  assign w_wrap     = w_capture && (r_idx == r_last_idx);
  assign w_next_idx = r_idx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_last_idx    <= '0;
      r_base        <= '0;
      r_req_addr    <= '0;
      r_wdog        <= '0;
      r_sweep_done  <= 1'b0;
      r_sweep_count <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_sweep_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (scan_en) begin
            r_state    <= ST_FLUSH;
            r_base     <= base_addr;
            r_last_idx <= last_idx(num_entries);
            r_req_addr <= base_addr;
            r_idx      <= '0;
            r_wdog     <= '0;
          end
        end
        ST_FLUSH, ST_SCAN: begin
          if (!scan_en) begin
            r_state <= ST_IDLE;
          end else if (rd_valid) begin
            r_wdog <= '0;
            // The first word after FLUSH may belong to a stale address and is dropped.
            if (r_state == ST_FLUSH) begin
              r_state <= ST_SCAN;
            end else if (w_wrap) begin
              r_idx        <= '0;
              r_base       <= base_addr;
              r_last_idx   <= last_idx(num_entries);
              r_req_addr   <= base_addr;
              r_sweep_done <= 1'b1;
              if (r_sweep_count != 16'hFFFF) r_sweep_count <= r_sweep_count + 16'd1;
            end else begin
              r_idx      <= w_next_idx;
              r_req_addr <= r_base + DRP_ADDR_W'(w_next_idx);
            end
          end else if (r_wdog == WDOG_W'(TIMEOUT_CYC - 1)) begin
            r_state       <= ST_ERR;
            r_timeout_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
        end
        ST_ERR: begin
          if (!scan_en) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  drp_scan_table u_table (
    .clk            (clk),
    .rst            (rst),
    .i_wr_en        (w_capture),
    .i_wr_idx       (r_idx),
    .i_wr_data      (rd_data),
    .i_host_rd      (host_rd),
    .i_host_idx     (host_idx),
    .i_change_clr   (change_clr),
    .o_host_data    (host_data),
    .o_host_data_vld(host_data_vld),
    .o_change_flag  (change_flag)
  );

  assign req_addr    = r_req_addr;
  assign sweep_done  = r_sweep_done;
  assign sweep_count = r_sweep_count;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_drp_scan_ctrl.sv
// Self-checking bench for drp_scan_ctrl: directed scenarios plus randomized sweeps
// against a capture-level reference model, with scoreboarded host reads and sweep_done pulses.
module tb_drp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [7:0]  base_addr;
  logic [4:0]  num_entries;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [7:0]  req_addr;
  logic        host_rd;
  logic [3:0]  host_idx;
  logic [15:0] host_data;
  logic        host_data_vld;
  logic        change_clr;
  logic [15:0] change_flag;
  logic        sweep_done;
  logic [15:0] sweep_count;
  logic        timeout_err;

  always #5 clk = ~clk;

  drp_scan_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .scan_en      (scan_en),
    .base_addr    (base_addr),
    .num_entries  (num_entries),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .req_addr     (req_addr),
    .host_rd      (host_rd),
    .host_idx     (host_idx),
    .host_data    (host_data),
    .host_data_vld(host_data_vld),
    .change_clr   (change_clr),
    .change_flag  (change_flag),
    .sweep_done   (sweep_done),
    .sweep_count  (sweep_count),
    .timeout_err  (timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the table as the host should see it, and the sweep position.
  logic [15:0] m_mem [16];
  bit          m_valid [16];
  logic [15:0] m_flag;
  int          m_count;
  logic [7:0]  m_base;
  logic [7:0]  m_req;
  int          m_len;
  int          m_idx;
  bit          m_flushing;

  logic [15:0] exp_host_q[$];
  int          exp_sweep_q[$];

  function automatic int eff_len(input int n);
    if (n == 0) return 1;
    if (n > 16) return 16;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_flag  = 16'h0000;
    m_count = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan();
    scan_en    = 1'b1;
    m_base     = base_addr;
    m_len      = eff_len(int'(num_entries));
    m_idx      = 0;
    m_flushing = 1'b1;
    m_req      = base_addr;
    tick();
    check("req_addr_on_flush", req_addr, m_req);
  endtask

  task automatic stop_scan();
    scan_en = 1'b0;
    tick();
  endtask

  // One cycle with no capture, optionally clearing flags and/or issuing a host read.
  task automatic gap(input bit clr, input bit hrd, input int hidx);
    change_clr = clr;
    host_rd    = hrd;
    host_idx   = 4'(hidx);
    if (hrd) exp_host_q.push_back(m_valid[hidx] ? m_mem[hidx] : 16'h0000);
    if (clr) m_flag = 16'h0000;
    tick();
    change_clr = 1'b0;
    host_rd    = 1'b0;
    check("change_flag_gap", change_flag, m_flag);
  endtask

  // One rd_valid pulse while scanning, with optional coincident clear and host read.
  task automatic capture(input logic [15:0] data, input bit clr, input bit hrd, input int hidx);
    rd_valid   = 1'b1;
    rd_data    = data;
    change_clr = clr;
    host_rd    = hrd;
    host_idx   = 4'(hidx);
    if (hrd) exp_host_q.push_back(m_valid[hidx] ? m_mem[hidx] : 16'h0000);
    if (clr) m_flag = 16'h0000;
    if (m_flushing) begin
      m_flushing = 1'b0;
    end else begin
      if (m_valid[m_idx] && m_mem[m_idx] != data) m_flag[m_idx] = 1'b1;
      m_mem[m_idx]   = data;
      m_valid[m_idx] = 1'b1;
      if (m_idx == m_len - 1) begin
        m_idx = 0;
        if (m_count < 65535) m_count++;
        exp_sweep_q.push_back(m_count);
        m_base = base_addr;
        m_len  = eff_len(int'(num_entries));
      end else begin
        m_idx++;
      end
      m_req = m_base + 8'(m_idx);
    end
    tick();
    rd_valid   = 1'b0;
    change_clr = 1'b0;
    host_rd    = 1'b0;
    check("req_addr", req_addr, m_req);
    check("change_flag", change_flag, m_flag);
  endtask

  // Monitor: pops expectations whenever the DUT presents a qualified output.
  always @(negedge clk) begin
    if (sweep_done === 1'b1) begin
      if (exp_sweep_q.size() == 0) check("sweep_done_unexpected", 32'(sweep_done), 32'd0);
      else check("sweep_count_at_done", 32'(sweep_count), 32'(exp_sweep_q.pop_front()));
    end
    if (host_data_vld === 1'b1) begin
      if (exp_host_q.size() == 0) check("host_vld_unexpected", 32'(host_data_vld), 32'd0);
      else check("host_data", 32'(host_data), 32'(exp_host_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, got no finish, expected finish");
    $fatal(1);
  end

  logic [15:0] s1 [4] = '{16'h1111, 16'h2222, 16'h1234, 16'h4444};

  task automatic check_all_zero(input string tag);
    check({tag, "_req_addr"},    32'(req_addr),      32'd0);
    check({tag, "_host_data"},   32'(host_data),     32'd0);
    check({tag, "_host_vld"},    32'(host_data_vld), 32'd0);
    check({tag, "_change_flag"}, 32'(change_flag),   32'd0);
    check({tag, "_sweep_done"},  32'(sweep_done),    32'd0);
    check({tag, "_sweep_count"}, 32'(sweep_count),   32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err),   32'd0);
  endtask

  initial begin
    rst = 1'b1; scan_en = 1'b0; base_addr = '0; num_entries = '0;
    rd_valid = 1'b0; rd_data = '0; host_rd = 1'b0; host_idx = '0; change_clr = 1'b0;
    model_reset();
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Basic sweep: read engine returns its address as data every 4 cycles.
    base_addr = 8'h40; num_entries = 5'd4;
    start_scan();
    for (int i = 0; i < 9; i++) begin
      repeat (3) gap(1'b0, 1'b0, 0);
      capture(16'(m_req), 1'b0, 1'b0, 0);
    end
    gap(1'b0, 1'b1, 3);
    check("sweep_count_basic", 32'(sweep_count), 32'd2);
    stop_scan();

    // Address wrap past 0xFF, then single-entry window.
    base_addr = 8'hFE; num_entries = 5'd3;
    start_scan();
    for (int i = 0; i < 7; i++) capture(16'(m_req), 1'b0, 1'b0, 0);
    stop_scan();
    base_addr = 8'h10; num_entries = 5'd0;
    start_scan();
    for (int i = 0; i < 5; i++) capture(16'h0100 + 16'(i), 1'b0, 1'b0, 0);
    stop_scan();

    // Change detection and clear/set collision on entry 2.
    base_addr = 8'h00; num_entries = 5'd4;
    start_scan();
    capture(16'h0000, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) capture(s1[i], 1'b0, 1'b0, 0);
    gap(1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) capture((i == 2) ? 16'h1235 : s1[i], 1'b0, 1'b0, 0);
    check("change_flag_entry2", 32'(change_flag), 32'h0004);
    for (int i = 0; i < 4; i++) capture((i == 2) ? 16'h1236 : s1[i], i == 2, 1'b0, 0);
    check("change_flag_set_wins", 32'(change_flag), 32'h0004);

    // Host read colliding with a write to the same entry.
    capture(16'h0001, 1'b0, 1'b0, 0);
    capture(16'hAAAA, 1'b0, 1'b0, 0);
    capture(16'h0003, 1'b0, 1'b0, 0);
    capture(16'h0004, 1'b0, 1'b0, 0);
    capture(16'h0001, 1'b0, 1'b0, 0);
    capture(16'hBEEF, 1'b0, 1'b1, 1);
    gap(1'b0, 1'b1, 1);
    stop_scan();

    // Abort mid-sweep, then restart.
    base_addr = 8'h20; num_entries = 5'd4;
    start_scan();
    capture(16'h0F00, 1'b0, 1'b0, 0);
    capture(16'h0F01, 1'b0, 1'b0, 0);
    capture(16'h0F02, 1'b0, 1'b0, 0);
    stop_scan();
    repeat (3) gap(1'b0, 1'b0, 0);
    check("sweep_count_abort", 32'(sweep_count), 32'(m_count));
    start_scan();
    capture(16'h0F10, 1'b0, 1'b0, 0);
    capture(16'h0F11, 1'b0, 1'b0, 0);

    // Asynchronous reset in the middle of a sweep.
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    scan_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    base_addr = 8'h30; num_entries = 5'd2;
    start_scan();
    capture(16'h5555, 1'b0, 1'b0, 0);
    gap(1'b0, 1'b1, 1);
    capture(16'h7777, 1'b0, 1'b1, 0);
    capture(16'h8888, 1'b0, 1'b0, 0);
    stop_scan();

    // Randomized sweeps with mid-sweep window changes, host reads and clears.
    for (int r = 0; r < 8; r++) begin
      int n;
      base_addr   = 8'($urandom);
      num_entries = 5'($urandom_range(0, 31));
      start_scan();
      n = int'($urandom_range(6, 40));
      for (int k = 0; k < n; k++) begin
        int g;
        g = int'($urandom_range(0, 3));
        for (int j = 0; j < g; j++)
          gap($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)));
        if ($urandom_range(0, 7) == 0) begin
          base_addr   = 8'($urandom);
          num_entries = 5'($urandom_range(0, 31));
        end
        capture(16'h5A00 | 16'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)));
      end
      stop_scan();
      check("sweep_count_round", 32'(sweep_count), 32'(m_count));
    end

    // Watchdog: 1000 cycles of silence after the last capture.
    base_addr = 8'h80; num_entries = 5'd8;
    start_scan();
    for (int i = 0; i < 4; i++) capture(16'h0C00 + 16'(i), 1'b0, 1'b0, 0);
    repeat (999) tick();
    check("timeout_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("timeout_set", 32'(timeout_err), 32'd1);
    rd_valid = 1'b1; rd_data = 16'hDEAD;
    tick();
    rd_valid = 1'b0;
    check("err_req_addr_held", 32'(req_addr), 32'(m_req));
    check("err_flags_held", 32'(change_flag), 32'(m_flag));
    stop_scan();
    tick();
    check("timeout_sticky", 32'(timeout_err), 32'd1);
    start_scan();

    repeat (3) tick();
    check("sweep_queue_drained", 32'(exp_sweep_q.size()), 32'd0);
    check("host_queue_drained", 32'(exp_host_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
